// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared defaults, FSM state type and reset configuration
package seq_det_pkg;
    localparam int DATA_W_DEF  = 8;
    localparam int PAT_MAX_DEF = 8;
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam logic [7:0] RST_PATTERN = 8'b0000_0111;
    localparam logic [2:0] RST_LEN     = 3'd2;
    localparam logic       RST_OVERLAP = 1'b1;
endpackage

// File: rtl/seq_match_core.sv
// seq_match_core: bit history, seen counter, pattern compare and detected pulse
// Optional match counter under macro SEQ_DET_MATCH_CNT_EN.
module seq_match_core
    import seq_det_pkg::*;
#(
    parameter int PAT_MAX = PAT_MAX_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               bit_vld,
    input  logic               bit_in,
    input  logic [PAT_MAX-1:0] pattern,
    input  logic [2:0]         len,
    input  logic               overlap,
    output logic               detected
`ifdef SEQ_DET_MATCH_CNT_EN
    ,
    output logic [7:0]         match_cnt
`endif
);
    localparam int SW = $clog2(PAT_MAX + 1);
    logic [PAT_MAX-1:0] hist_q, hist_d, mask;
    logic [SW-1:0]      seen_q, seen_d, seen_inc;
    logic               det_q, det_d, match;
    // compare against the history as it will be after this bit enters
    always_comb begin
        hist_d   = clr ? '0 : bit_vld ? {hist_q[PAT_MAX-2:0], bit_in} : hist_q;
        for (int i = 0; i < PAT_MAX; i++) mask[i] = i <= int'(len);
        seen_inc = (seen_q == SW'(PAT_MAX)) ? seen_q : seen_q + SW'(1);
        match    = bit_vld && (seen_inc >= SW'(len) + SW'(1)) && (((hist_d ^ pattern) & mask) == '0);
        seen_d   = clr ? '0 : !bit_vld ? seen_q : (match && !overlap) ? '0 : seen_inc;
        det_d    = match;
    end
    // history, seen and detected registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            seen_q <= '0;
            det_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            seen_q <= seen_d;
            det_q  <= det_d;
        end
    end
    assign detected = det_q;
`ifdef SEQ_DET_MATCH_CNT_EN
    logic [7:0] cnt_q, cnt_d;
    // saturating count of matches, cleared on configuration write
    always_comb begin
        cnt_d = clr ? 8'd0 : (det_d && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    end
    // match counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= 8'd0;
        else        cnt_q <= cnt_d;
    end
    assign match_cnt = cnt_q;
`endif
endmodule

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: word handshake, MSB-first serializer and config registers for a sequence detector
// Optional match counter under macro SEQ_DET_MATCH_CNT_EN.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PAT_MAX = PAT_MAX_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [2:0]         cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic               busy,
    output logic               detected
`ifdef SEQ_DET_MATCH_CNT_EN
    ,
    output logic [7:0]         match_cnt
`endif
);
    localparam int IW = $clog2(DATA_W);
    state_t             state_q, state_d;
    logic [DATA_W-1:0]  sr_q, sr_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [PAT_MAX-1:0] pat_q, pat_d;
    logic [2:0]         len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               last, accept, cfg_upd;
    // handshake and next state; the last-bit cycle accepts a new word so words run back to back
    always_comb begin
        busy     = state_q == SHIFT;
        last     = idx_q == IW'(DATA_W - 1);
        in_ready = busy ? last : !cfg_we;
        accept   = in_valid && in_ready;
        cfg_upd  = cfg_we && !busy;
        state_d  = accept ? SHIFT : (busy && last) ? IDLE : state_q;
        sr_d     = accept ? in_data : busy ? {sr_q[DATA_W-2:0], 1'b0} : sr_q;
        idx_d    = accept ? '0 : busy ? idx_q + IW'(1) : idx_q;
        pat_d    = cfg_upd ? cfg_pattern : pat_q;
        len_d    = cfg_upd ? cfg_len : len_q;
        ovl_d    = cfg_upd ? cfg_overlap : ovl_q;
    end
    // FSM, shifter and configuration registers; reset restores the "111" detector
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            idx_q   <= '0;
            pat_q   <= PAT_MAX'(RST_PATTERN);
            len_q   <= RST_LEN;
            ovl_q   <= RST_OVERLAP;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            idx_q   <= idx_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
        end
    end
    seq_match_core #(.PAT_MAX(PAT_MAX)) u_core (
        .clk      (clk),
        .reset    (reset),
        .clr      (cfg_upd),
        .bit_vld  (busy),
        .bit_in   (sr_q[DATA_W-1]),
        .pattern  (pat_q),
        .len      (len_q),
        .overlap  (ovl_q),
        .detected (detected)
`ifdef SEQ_DET_MATCH_CNT_EN
        ,
        .match_cnt(match_cnt)
`endif
    );
endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: directed self-checking bench for seq_det_ctrl (match counter under SEQ_DET_MATCH_CNT_EN)
module tb_seq_det_ctrl;
    logic       clk, reset, cfg_we, cfg_overlap, in_valid;
    logic [7:0] cfg_pattern, in_data;
    logic [2:0] cfg_len;
    logic       in_ready, busy, detected;
`ifdef SEQ_DET_MATCH_CNT_EN
    logic [7:0] match_cnt;
`endif
    int checks = 0;
    int failures = 0;

    seq_det_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .busy       (busy),
        .detected   (detected)
`ifdef SEQ_DET_MATCH_CNT_EN
        ,
        .match_cnt  (match_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic cfg(input logic [7:0] pat, input logic [2:0] len, input logic ovl);
        @(negedge clk);
        cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
        in_valid = 1'b1; in_data = 8'hFF;
        #1 chk("cfg_rdy", 32'(in_ready), 0);
        @(negedge clk);
        cfg_we = 1'b0; in_valid = 1'b0;
        chk("cfg_noacc", 32'(busy), 0);
    endtask

    task automatic send(input logic [7:0] w, output logic [7:0] p);
        logic [7:0] bv;
        @(negedge clk);
        in_valid = 1'b1; in_data = w;
        chk("acc_rdy", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            p[k]  = detected;
            bv[k] = busy;
        end
        chk("word_busy", 32'(bv), 32'h7F);
    endtask

    initial begin
        logic [7:0]  p;
        logic [15:0] p16, b16;
        logic        d;
        reset = 1'b0; cfg_we = 1'b0; cfg_pattern = 8'h00; cfg_len = 3'd0;
        cfg_overlap = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_det", 32'(detected), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_rdy", 32'(in_ready), 1);
        chk("rel_busy", 32'(busy), 0);
        chk("rel_det", 32'(detected), 0);
`ifdef SEQ_DET_MATCH_CNT_EN
        chk("rel_cnt", 32'(match_cnt), 0);
`endif
        send(8'b1110_1111, p);
        chk("ovl_pulses", 32'(p), 32'hC4);
        cfg(8'h07, 3'd2, 1'b0);
        send(8'b1110_1111, p);
        chk("novl_pulses", 32'(p), 32'h44);
        cfg(8'h07, 3'd2, 1'b1);
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h01;
        @(negedge clk);
        in_data = 8'hC0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            p16[i] = detected;
            b16[i] = busy;
            if (i == 5) chk("b2b_rdy_mid", 32'(in_ready), 0);
            if (i == 6) chk("b2b_rdy_last", 32'(in_ready), 1);
            if (i == 7) in_valid = 1'b0;
        end
        chk("b2b_pulses", 32'(p16), 32'h0200);
        chk("b2b_busy", 32'(b16), 32'h7FFF);
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hE0;
        @(negedge clk);
        in_valid = 1'b0;
        cfg_we = 1'b1; cfg_pattern = 8'hA5; cfg_len = 3'd7; cfg_overlap = 1'b0;
        #1 chk("busy_cfg_rdy", 32'(in_ready), 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            p[k] = detected;
            if (k == 2) cfg_we = 1'b0;
        end
        chk("busy_cfg_ignored", 32'(p), 32'h04);
        cfg(8'hA5, 3'd7, 1'b1);
        send(8'hA5, p);
        chk("a5_pulses", 32'(p), 32'h80);
        cfg(8'h00, 3'd3, 1'b1);
        send(8'h00, p);
        chk("zero_seen_gate", 32'(p), 32'hF8);
        do_reset();
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_det", 32'(detected), 0);
        chk("mid_rst_rdy", 32'(in_ready), 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        d = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            d = d | detected | busy;
        end
        chk("mid_rst_quiet", 32'(d), 0);
        send(8'hE0, p);
        chk("rst_defaults", 32'(p), 32'h04);
`ifdef SEQ_DET_MATCH_CNT_EN
        cfg(8'h01, 3'd0, 1'b1);
        send(8'hFF, p);
        chk("cnt_one_word", 32'(match_cnt), 8);
        for (int w = 0; w < 37; w++) send(8'hFF, p);
        chk("cnt_sat", 32'(match_cnt), 255);
        cfg(8'h07, 3'd2, 1'b1);
        chk("cnt_clr", 32'(match_cnt), 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning input word width in bits, legal range 2..16.
REQ-002 The block SHALL have parameter PAT_MAX, default 8, meaning the maximum pattern length in bits.
REQ-003 Port clk  in  1  is the single clock; all state SHALL be updated on the rising edge.
REQ-004 Port reset  in  1  is the reset; it SHALL be asynchronous and active-low.
REQ-005 Port cfg_we  in  1  is the configuration write strobe.
REQ-006 Port cfg_pattern  in  PAT_MAX  is the pattern; it is right-aligned and the LSB is the most recent bit.
REQ-007 Port cfg_len  in  3  is the pattern length minus 1 (0..7, giving 1..8 bits).
REQ-008 Port cfg_overlap  in  1  selects overlap mode when 1 and non-overlap mode when 0.
REQ-009 Port in_valid  in  1  indicates that the word on in_data is valid.
REQ-010 Port in_data  in  DATA_W  is the word to serialize, MSB first.
REQ-011 Port in_ready  out  1  indicates the controller can accept a word.
REQ-012 Port busy  out  1  is high while a word is being serialized.
REQ-013 Port detected  out  1  is a registered one-cycle pulse per pattern match.
REQ-014 Port match_cnt  out  8  is the saturating match count; it exists only under the macro in REQ-032.

Function
REQ-015 States SHALL be IDLE and SHIFT; a bit-index counter SHALL run 0..DATA_W-1 during SHIFT.
REQ-016 IDLE: in_ready = !cfg_we; in_valid&&in_ready SHALL load the shift register, clear the index and enter SHIFT.
REQ-017 SHIFT: each cycle SHALL shift one bit (MSB first) into the history register and increment the index.
REQ-018 SHIFT with index==DATA_W-1: in_ready SHALL be 1; an accept SHALL reload and stay in SHIFT (no bubble), otherwise the block SHALL go to IDLE.
REQ-019 busy SHALL equal (state==SHIFT).
REQ-020 Bit k of a word accepted at edge A SHALL enter history at edge A+1+k.
REQ-021 seen counter: it SHALL count bits entered, saturating at PAT_MAX.
REQ-022 Match: seen>=cfg_len+1 and the low cfg_len+1 bits of the next history equal the low cfg_len+1 bits of cfg_pattern; detected SHALL be registered at the same edge the completing bit enters.
REQ-023 Non-overlap mode: a match SHALL clear seen to 0 at that edge; overlap mode SHALL leave seen unchanged.
REQ-024 History and seen SHALL persist across words; matches may span word boundaries.
REQ-025 cfg_we in IDLE SHALL latch pattern/len/overlap and clear history, seen and match_cnt; no word is accepted that cycle.
REQ-026 cfg_we while busy SHALL be ignored entirely.
REQ-027 in_valid while in_ready=0 SHALL have no effect; the producer holds the word.

Reset
REQ-028 Reset asserted SHALL give state IDLE, in_ready 1 (after the reset release edge), busy 0, detected 0, history 0, seen 0, and match_cnt 0.
REQ-029 Reset SHALL restore the configuration to pattern 8'b0000_0111, cfg_len 2 and overlap 1 (the "111" detector).
REQ-030 Reset mid-word SHALL discard the word with no detected pulse.

Configuration
REQ-031 The macro SEQ_DET_MATCH_CNT_EN, when defined, SHALL add match_cnt, which increments per detected and saturates at 255.
REQ-032 Without SEQ_DET_MATCH_CNT_EN, the port match_cnt and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-033 Package seq_det_pkg SHALL hold DATA_W and PAT_MAX defaults, the state enum (IDLE, SHIFT) and the reset-default pattern/len/overlap constants.
REQ-034 Sub-module seq_match_core SHALL hold history, the seen counter, the compare and the detected register; seq_det_ctrl SHALL hold the handshake, the shifter and the configuration registers.

Verification
REQ-035 Case: after reset, defaults, word 8'b1110_1111. Required: 3 detected pulses, after bits 3, 7 and 8 (edges A+3, A+7, A+8).
REQ-036 Case: same word with cfg_overlap=0. Required: 2 pulses, after bits 3 and 7 only.
REQ-037 Case: back-to-back words 8'h01 then 8'hC0 with in_valid held. Required: no idle cycle, in_ready high at the last-bit cycle, and 1 pulse spanning the boundary (bits 8, 9, 10).
REQ-038 Case: cfg_we while busy with pattern 8'hA5, len 7. Required: ignored and the old pattern still matches; a write in IDLE then matches word 8'hA5 exactly once.
REQ-039 Case: reset asserted at bit 2 of 8'hFF. Required: outputs return to reset values immediately and no pulse occurs.
REQ-040 Case: with SEQ_DET_MATCH_CNT_EN, 300 matches. Required: match_cnt == 255; cfg_we returns it to 0.
